fifo_apb_ctrl: RTL
==================

FIFO_APB_CTRL -- requirements
Module: fifo_apb_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, FIFO word and register width.
REQ-002 Parameter CNT_W, default 5, width of FIFO occupancy count (depth 16).
REQ-003 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 PRESET  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  access strobe from APB slave, one cycle per access.
REQ-006 req_write  in  1  1 = write access, 0 = read access.
REQ-007 req_addr  in  8  byte address of accessed register.
REQ-008 req_wdata  in  DATA_W  write data.
REQ-009 req_ready  out  1  high when a request can be accepted; equals (state==IDLE).
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-012 rsp_err  out  1  error flag, valid with rsp_valid.
REQ-013 fifo_push  out  1  FIFO write strobe, one cycle.
REQ-014 fifo_wdata  out  DATA_W  FIFO write data.
REQ-015 fifo_pop  out  1  FIFO read strobe, one cycle.
REQ-016 fifo_rdata  in  DATA_W  FIFO read data, valid the cycle after fifo_pop.
REQ-017 fifo_full, fifo_empty  in  1 each  FIFO status flags.
REQ-018 fifo_count  in  CNT_W  FIFO occupancy.
REQ-019 irq  out  1  registered interrupt, level.

Function
REQ-020 Register map: 0x00 DATA (W = push, R = pop); 0x04 STATUS (RO); 0x08 CTRL (RW); 0x0C CLEAR (WO, write-1-to-clear).
REQ-021 STATUS: bit0 empty, bit1 full, bits[8+CNT_W-1:8] count, bit16 ovf sticky, bit17 udf sticky, all others 0.
REQ-022 CTRL: bit0 enable, bit1 irq_en, bits[12:8] threshold; unused bits read 0, writes to them ignored.
REQ-023 CLEAR: bit16 clears ovf, bit17 clears udf; reads of CLEAR and writes to STATUS return rsp_err=1 with no side effect.
REQ-024 FSM states IDLE, POP, CAPT, RESP; request accepted only when req_valid and state==IDLE; req_valid in any other state is ignored.
REQ-025 Non-DATA-read access accepted in cycle T: IDLE->RESP; rsp_valid=1 in cycle T+1; register write takes effect at T+1.
REQ-026 DATA write at T with enable=1 and fifo_full=0: fifo_push=1 and fifo_wdata=req_wdata in T+1, rsp_err=0.
REQ-027 DATA write with fifo_full=1: no push, ovf set, rsp_err=1 at T+1.
REQ-028 DATA read at T with enable=1 and fifo_empty=0: IDLE->POP (T+1, fifo_pop=1)->CAPT (T+2, fifo_rdata latched)->RESP (T+3, rsp_valid=1, rsp_rdata=latched word, rsp_err=0)->IDLE.
REQ-029 DATA read with fifo_empty=1: no pop, udf set, IDLE->RESP, rsp_err=1, rsp_rdata=0 at T+1.
REQ-030 DATA access with enable=0: no push/pop, no sticky update, rsp_err=1.
REQ-031 Unmapped address or req_addr[1:0]!=0: no side effect, rsp_err=1, rsp_rdata=0.
REQ-032 rsp_rdata=0 on every write response and every errored response.
REQ-033 fifo_push, fifo_pop, rsp_valid are never high for more than one cycle per accepted request; push and pop never coincide.
REQ-034 irq registered: irq_en & ((fifo_count >= threshold) | ovf | udf); threshold=0 with irq_en=1 gives irq=1.
REQ-035 RESP always returns to IDLE next cycle; req_ready=1 in that following cycle.

Reset
REQ-036 PRESET high at a rising edge takes priority over all other activity.
REQ-037 After reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, fifo_push=0, fifo_pop=0, fifo_wdata=0, irq=0, ovf=udf=0, CTRL=0x00000001 (enable=1, irq_en=0, threshold=0).
REQ-038 Reset in POP/CAPT/RESP aborts the access: no rsp_valid is produced; a word already popped is discarded.

Verification
REQ-039 Reset, write 0xA5A5_0001 to 0x00 -> fifo_push=1, fifo_wdata=0xA5A50001 at T+1, rsp_valid=1, rsp_err=0.
REQ-040 FIFO holds 0x1234_5678, read 0x00 at T -> fifo_pop at T+1, rsp_valid at T+3 with rsp_rdata=0x12345678, rsp_err=0.
REQ-041 fifo_empty=1, read 0x00 -> rsp_err=1, rsp_rdata=0 at T+1, STATUS read returns bit17=1; write 0x00020000 to 0x0C -> bit17=0.
REQ-042 CTRL=0x00000403 (enable, irq_en, threshold 4), fifo_count 3->4 -> irq rises one cycle later; count back to 3 -> irq falls.
REQ-043 Read 0x10 and 0x02 -> rsp_err=1, rsp_rdata=0, no push/pop; CTRL write 0x0 then DATA write -> rsp_err=1, no push.
REQ-044 PRESET asserted in CAPT -> no rsp_valid, next cycle req_ready=1, CTRL reads 0x00000001.

Source files
------------

// File: rtl/fifo_apb_ctrl.sv
// Register front end for a 16-deep FIFO: DATA push/pop, STATUS, CTRL and CLEAR registers.
// One access at a time; DATA reads detour through POP/CAPT to wait for the FIFO read data.
module fifo_apb_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [7:0]        req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              fifo_push,
   output logic [DATA_W-1:0] fifo_wdata,
   output logic              fifo_pop,
   input  logic [DATA_W-1:0] fifo_rdata,
   input  logic              fifo_full,
   input  logic              fifo_empty,
   input  logic [CNT_W-1:0]  fifo_count,
   output logic              irq
);

   localparam int unsigned THR_W = 5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_POP  = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [7:0] A_DATA   = 8'h00;
   localparam logic [7:0] A_STATUS = 8'h04;
   localparam logic [7:0] A_CTRL   = 8'h08;
   localparam logic [7:0] A_CLEAR  = 8'h0C;

   logic [1:0]        state_q,     state_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;
   logic              push_q,      push_d;
   logic [DATA_W-1:0] wdata_q,     wdata_d;
   logic              pop_q,       pop_d;
   logic              irq_q,       irq_d;
   logic              en_q,        en_d;
   logic              irq_en_q,    irq_en_d;
   logic [THR_W-1:0]  thr_q,       thr_d;
   logic              ovf_q,       ovf_d;
   logic              udf_q,       udf_d;

   logic [DATA_W-1:0] status_rd;
   logic [DATA_W-1:0] ctrl_rd;

   // Read views of STATUS and CTRL; unused bits read as zero
   always_comb begin
      status_rd             = '0;
      status_rd[0]          = fifo_empty;
      status_rd[1]          = fifo_full;
      status_rd[8 +: CNT_W] = fifo_count;
      status_rd[16]         = ovf_q;
      status_rd[17]         = udf_q;
      ctrl_rd               = '0;
      ctrl_rd[0]            = en_q;
      ctrl_rd[1]            = irq_en_q;
      ctrl_rd[8 +: THR_W]   = thr_q;
   end

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      push_d      = 1'b0;
      wdata_d     = wdata_q;
      pop_d       = 1'b0;
      en_d        = en_q;
      irq_en_d    = irq_en_q;
      thr_d       = thr_q;
      ovf_d       = ovf_q;
      udf_d       = udf_q;
      irq_d       = irq_en_q & ((32'(fifo_count) >= 32'(thr_q)) | ovf_q | udf_q);

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d     = S_RESP;
               rsp_valid_d = 1'b1;
               case (req_addr)
                  A_DATA: begin
                     if (!en_q) begin
                        rsp_err_d = 1'b1;
                     end else if (req_write) begin
                        if (fifo_full) begin
                           ovf_d     = 1'b1;
                           rsp_err_d = 1'b1;
                        end else begin
                           push_d  = 1'b1;
                           wdata_d = req_wdata;
                        end
                     end else if (fifo_empty) begin
                        udf_d     = 1'b1;
                        rsp_err_d = 1'b1;
                     end else begin
                        // Response is deferred until the popped word is captured
                        state_d     = S_POP;
                        rsp_valid_d = 1'b0;
                        pop_d       = 1'b1;
                     end
                  end
                  A_STATUS: begin
                     if (req_write) rsp_err_d   = 1'b1;
                     else           rsp_rdata_d = status_rd;
                  end
                  A_CTRL: begin
                     if (req_write) begin
                        en_d     = req_wdata[0];
                        irq_en_d = req_wdata[1];
                        thr_d    = req_wdata[8 +: THR_W];
                     end else begin
                        rsp_rdata_d = ctrl_rd;
                     end
                  end
                  A_CLEAR: begin
                     if (req_write) begin
                        if (req_wdata[16]) ovf_d = 1'b0;
                        if (req_wdata[17]) udf_d = 1'b0;
                     end else begin
                        rsp_err_d = 1'b1;
                     end
                  end
                  default: rsp_err_d = 1'b1;
               endcase
            end
         end
         S_POP:  state_d = S_CAPT;
         S_CAPT: begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fifo_rdata;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q     <= S_IDLE;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         push_q      <= 1'b0;
         wdata_q     <= '0;
         pop_q       <= 1'b0;
         irq_q       <= 1'b0;
         en_q        <= 1'b1;
         irq_en_q    <= 1'b0;
         thr_q       <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         push_q      <= push_d;
         wdata_q     <= wdata_d;
         pop_q       <= pop_d;
         irq_q       <= irq_d;
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         thr_q       <= thr_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_err    = rsp_err_q;
   assign fifo_push  = push_q;
   assign fifo_wdata = wdata_q;
   assign fifo_pop   = pop_q;
   assign irq        = irq_q;

endmodule
